// File: rtl/prime_guess_scorer.sv
// Game-control stage around the LFSR prime generator: pulses the generator,
// latches its prime, arbitrates guesses under a time limit, tracks score and lives.
module prime_guess_scorer #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LIVES          = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] prime_in,
  input  logic [6:0] guess,
  input  logic       guess_submit,
  output logic       gen_enable,
  output logic [6:0] target,
  output logic       round_active,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic [6:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int unsigned SettleW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TimeoutW = 16;
  localparam logic [SettleW-1:0]  SettleLast  = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]          LivesInit   = 2'(LIVES);
  localparam logic [6:0]          ScoreMax    = 7'd127;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GEN    = 3'd1,
    SETTLE = 3'd2,
    ARMED  = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } stateE;

  stateE               state, stateNext;
  logic [SettleW-1:0]  settleCnt, settleCntNext;
  logic [TimeoutW-1:0] toCnt, toCntNext;
  logic [6:0]          targetNext, scoreNext;
  logic [1:0]          livesNext;
  logic                correctNext, wrongNext, timeoutNext;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state, counter and result decode
  always_comb begin
    stateNext     = state;
    settleCntNext = settleCnt;
    toCntNext     = toCnt;
    targetNext    = target;
    scoreNext     = score;
    livesNext     = lives;
    correctNext   = 1'b0;
    wrongNext     = 1'b0;
    timeoutNext   = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = GEN;
      end
      GEN: begin
        settleCntNext = '0;
        stateNext     = SETTLE;
      end
      SETTLE: begin
        if (settleCnt == SettleLast) begin
          targetNext = prime_in;
          toCntNext  = '0;
          stateNext  = ARMED;
        end else begin
          settleCntNext = settleCnt + SettleW'(1);
        end
      end
      ARMED: begin
        toCntNext = toCnt + TimeoutW'(1);
        // A submit on the final cycle takes priority over the timeout
        if (guess_submit) begin
          stateNext = RESULT;
          if (guess == target) begin
            correctNext = 1'b1;
            if (score != ScoreMax) scoreNext = score + 7'd1;
          end else begin
            wrongNext = 1'b1;
            if (lives != 2'd0) livesNext = lives - 2'd1;
          end
        end else if (toCnt == TimeoutLast) begin
          stateNext   = RESULT;
          timeoutNext = 1'b1;
          if (lives != 2'd0) livesNext = lives - 2'd1;
        end
      end
      RESULT: begin
        stateNext = (lives == 2'd0) ? OVER : GEN;
      end
      OVER: begin
        if (start) begin
          scoreNext = '0;
          livesNext = LivesInit;
          stateNext = GEN;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settleCnt    <= '0;
      toCnt        <= '0;
      target       <= '0;
      score        <= '0;
      lives        <= LivesInit;
      correct      <= 1'b0;
      wrong        <= 1'b0;
      timeout      <= 1'b0;
      gen_enable   <= 1'b0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      settleCnt    <= settleCntNext;
      toCnt        <= toCntNext;
      target       <= targetNext;
      score        <= scoreNext;
      lives        <= livesNext;
      correct      <= correctNext;
      wrong        <= wrongNext;
      timeout      <= timeoutNext;
      gen_enable   <= (stateNext == GEN);
      round_active <= (stateNext == ARMED);
      game_over    <= (stateNext == OVER);
    end
  end

endmodule
